// File: rtl/clk_fmeas_mon.sv
// clk_fmeas_mon: N-channel toggle-rate meter with min/max range check.
// Ports: pl_clk0/pl_reset_n, enable, ch_tog, ch_min/ch_max, fault_clr in;
//   ch_count, count_valid, ch_in_range, ch_fault, busy out.
//   Macro CLK_FMEAS_MON_IRQ_EN adds irq_mask (in) and irq (out).
module clk_fmeas_mon #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 24,
  parameter int GATE_CYCLES = 1000000,
  parameter int SYNC_FF     = 3
) (
  input  logic                    pl_clk0,
  input  logic                    pl_reset_n,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       ch_tog,
  input  logic [NUM_CH*CNT_W-1:0] ch_min,
  input  logic [NUM_CH*CNT_W-1:0] ch_max,
  input  logic                    fault_clr,
`ifdef CLK_FMEAS_MON_IRQ_EN
  input  logic [NUM_CH-1:0]       irq_mask,
  output logic                    irq,
`endif
  output logic [NUM_CH*CNT_W-1:0] ch_count,
  output logic                    count_valid,
  output logic [NUM_CH-1:0]       ch_in_range,
  output logic [NUM_CH-1:0]       ch_fault,
  output logic                    busy
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST =
    GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_GATE,
    S_LATCH
  } state_t;

  state_t state_q, state_d;

  logic [NUM_CH-1:0] sync_q [SYNC_FF];
  logic [NUM_CH-1:0] prev_q;
  logic [NUM_CH-1:0] evt;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [GW-1:0]     gcnt_q;
  logic [NUM_CH-1:0] in_rng_d;
  logic [NUM_CH-1:0] fault_set;
  logic              latch;

  always_ff @(posedge pl_clk0 or negedge pl_reset_n) begin
    if (!pl_reset_n) begin
      for (int k = 0; k < SYNC_FF; k++)
        sync_q[k] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= ch_tog;
      for (int k = 1; k < SYNC_FF; k++)
        sync_q[k] <= sync_q[k-1];
      prev_q <= sync_q[SYNC_FF-1];
    end
  end

  assign evt   = sync_q[SYNC_FF-1] ^ prev_q;
  assign latch = (state_q == S_LATCH);
  assign busy  = (state_q != S_IDLE);

  always_ff @(posedge pl_clk0 or negedge pl_reset_n) begin
    if (!pl_reset_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (enable) state_d = S_ARM;
      S_ARM:   state_d = enable ? S_GATE : S_IDLE;
      S_GATE: begin
        if (!enable)
          state_d = S_IDLE;
        else if (gcnt_q == GATE_LAST)
          state_d = S_LATCH;
      end
      S_LATCH: state_d = enable ? S_ARM : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pl_clk0 or negedge pl_reset_n) begin
    if (!pl_reset_n) begin
      gcnt_q <= '0;
      for (int i = 0; i < NUM_CH; i++)
        cnt_q[i] <= '0;
    end else if (state_q == S_ARM) begin
      gcnt_q <= '0;
      for (int i = 0; i < NUM_CH; i++)
        cnt_q[i] <= '0;
    end else if (state_q == S_GATE) begin
      gcnt_q <= gcnt_q + 1'b1;
      for (int i = 0; i < NUM_CH; i++)
        if (evt[i] && cnt_q[i] != CNT_MAX)
          cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  end

  always_comb begin
    in_rng_d = '0;
    for (int i = 0; i < NUM_CH; i++)
      in_rng_d[i] =
        (ch_min[i*CNT_W +: CNT_W] <= cnt_q[i]) &&
        (cnt_q[i] <= ch_max[i*CNT_W +: CNT_W]);
  end

  // Failures assert on the latch edge and are re-asserted
  // during the count_valid cycle so a clear there loses.
  always_comb begin
    fault_set = '0;
    if (latch)
      fault_set = ~in_rng_d;
    else if (count_valid)
      fault_set = ~ch_in_range;
  end

  always_ff @(posedge pl_clk0 or negedge pl_reset_n) begin
    if (!pl_reset_n) begin
      count_valid <= 1'b0;
      ch_count    <= '0;
      ch_in_range <= '0;
      ch_fault    <= '0;
    end else begin
      count_valid <= latch;
      if (latch) begin
        for (int i = 0; i < NUM_CH; i++)
          ch_count[i*CNT_W +: CNT_W] <= cnt_q[i];
        ch_in_range <= in_rng_d;
      end
      ch_fault <= (ch_fault & ~{NUM_CH{fault_clr}})
                | fault_set;
    end
  end

`ifdef CLK_FMEAS_MON_IRQ_EN
  always_ff @(posedge pl_clk0 or negedge pl_reset_n) begin
    if (!pl_reset_n)
      irq <= 1'b0;
    else
      irq <= |(ch_fault & ~irq_mask);
  end
`endif

endmodule

// File: tb/tb_clk_fmeas_mon.sv
// tb_clk_fmeas_mon: randomized scoreboard bench for clk_fmeas_mon.
// Main DUT uses 24-bit counts; a second 4-bit instance checks saturation.
module tb_clk_fmeas_mon;

  localparam int G  = 100;
  localparam int L  = 4;
  localparam int NC = 4;

  typedef struct {
    int          e;
    logic [95:0] cnt;
    logic [15:0] cnt4;
    logic [3:0]  inr;
  } rec_t;

  logic        pl_clk0;
  logic        pl_reset_n;
  logic        enable;
  logic [3:0]  ch_tog;
  logic [95:0] ch_min;
  logic [95:0] ch_max;
  logic        fault_clr;
  logic [95:0] ch_count;
  logic        count_valid;
  logic [3:0]  ch_in_range;
  logic [3:0]  ch_fault;
  logic        busy;

  logic [15:0] min4;
  logic [15:0] max4;
  logic [15:0] ch_count4;
  logic        count_valid4;
  logic [3:0]  ch_in_range4;
  logic [3:0]  ch_fault4;
  logic        busy4;

`ifdef CLK_FMEAS_MON_IRQ_EN
  logic [3:0] irq_mask;
  logic       irq;
  logic       irq4;
`endif

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic clr_s = 1'b0;
  bit   mon_on = 0;
  bit   tog_on = 0;
  bit   ch1_hold = 1;

  int   exp_e[$];
  rec_t sb[$];
  int   tlog[NC][$];

  clk_fmeas_mon #(
    .NUM_CH(4), .CNT_W(24), .GATE_CYCLES(G), .SYNC_FF(3)
  ) dut (
    .pl_clk0     (pl_clk0),
    .pl_reset_n  (pl_reset_n),
    .enable      (enable),
    .ch_tog      (ch_tog),
    .ch_min      (ch_min),
    .ch_max      (ch_max),
    .fault_clr   (fault_clr),
`ifdef CLK_FMEAS_MON_IRQ_EN
    .irq_mask    (irq_mask),
    .irq         (irq),
`endif
    .ch_count    (ch_count),
    .count_valid (count_valid),
    .ch_in_range (ch_in_range),
    .ch_fault    (ch_fault),
    .busy        (busy)
  );

  clk_fmeas_mon #(
    .NUM_CH(4), .CNT_W(4), .GATE_CYCLES(G), .SYNC_FF(3)
  ) dut4 (
    .pl_clk0     (pl_clk0),
    .pl_reset_n  (pl_reset_n),
    .enable      (enable),
    .ch_tog      (ch_tog),
    .ch_min      (min4),
    .ch_max      (max4),
    .fault_clr   (fault_clr),
`ifdef CLK_FMEAS_MON_IRQ_EN
    .irq_mask    (irq_mask),
    .irq         (irq4),
`endif
    .ch_count    (ch_count4),
    .count_valid (count_valid4),
    .ch_in_range (ch_in_range4),
    .ch_fault    (ch_fault4),
    .busy        (busy4)
  );

  initial begin
    pl_clk0 = 1'b0;
    forever #5 pl_clk0 = ~pl_clk0;
  end

  initial forever begin
    @(posedge pl_clk0);
    clr_s = fault_clr;
    cyc++;
  end

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge pl_clk0);
  endtask

  // Toggle sources; every transition is logged with its drive cycle.
  initial begin
    int last2, last3;
    logic [3:0] nt;
    last2 = -10;
    last3 = -10;
    forever begin
      @(negedge pl_clk0);
      if (tog_on) begin
        nt = ch_tog;
        if (cyc % 2 == 0) nt[0] = ~nt[0];
        if (!ch1_hold && cyc % 3 == 0) nt[1] = ~nt[1];
        if (cyc - last2 >= 2 && $urandom_range(2) == 0) begin
          nt[2] = ~nt[2];
          last2 = cyc;
        end
        if (cyc - last3 >= 2 && $urandom_range(4) == 0) begin
          nt[3] = ~nt[3];
          last3 = cyc;
        end
        for (int ch = 0; ch < NC; ch++)
          if (nt[ch] != ch_tog[ch]) tlog[ch].push_back(cyc);
        ch_tog = nt;
      end
    end
  end

  // Reference: a transition driven at cycle n is seen L edges later,
  // so a result published at edge e covers drives in
  // [e-G-L, e-1-L].
  initial forever begin
    rec_t r;
    int   e, c, lo, hi;
    @(negedge pl_clk0);
    if (exp_e.size() != 0 && cyc == exp_e[0] - 1) begin
      e = exp_e.pop_front();
      r.e = e;
      r.cnt = '0;
      r.cnt4 = '0;
      r.inr = '0;
      for (int ch = 0; ch < NC; ch++) begin
        c = 0;
        for (int j = 0; j < tlog[ch].size(); j++)
          if (tlog[ch][j] >= e - G - L && tlog[ch][j] <= e - 1 - L)
            c++;
        lo = int'(ch_min[ch*24 +: 24]);
        hi = int'(ch_max[ch*24 +: 24]);
        r.cnt[ch*24 +: 24] = 24'(c);
        r.cnt4[ch*4 +: 4] = (c > 15) ? 4'hF : 4'(c);
        r.inr[ch] = (c >= lo) && (c <= hi);
      end
      sb.push_back(r);
    end
  end

  // Monitor: pops on count_valid and tracks held/sticky outputs.
  initial begin
    rec_t        r;
    logic        exp_cv;
    logic [95:0] m_cnt;
    logic [15:0] m_cnt4;
    logic [3:0]  m_inr, m_fault, cur_fail;
    int          cur_e;
    m_cnt = '0; m_cnt4 = '0; m_inr = '0; m_fault = '0;
    cur_fail = '0; cur_e = -10;
    forever begin
      @(negedge pl_clk0);
      if (!pl_reset_n) begin
        m_cnt = '0; m_cnt4 = '0; m_inr = '0; m_fault = '0;
        cur_fail = '0; cur_e = -10;
        sb.delete();
      end else if (mon_on) begin
        exp_cv = 1'b0;
        while (sb.size() != 0 && sb[0].e < cyc) begin
          checks++;
          failures++;
          $display("FAIL missing_valid: none at cyc %0d", sb[0].e);
          void'(sb.pop_front());
        end
        if (sb.size() != 0 && sb[0].e == cyc) begin
          r = sb.pop_front();
          exp_cv = 1'b1;
          m_cnt = r.cnt;
          m_cnt4 = r.cnt4;
          m_inr = r.inr;
          cur_e = cyc;
          cur_fail = ~r.inr;
        end
        if (exp_cv)
          m_fault = (m_fault & ~{4{clr_s}}) | cur_fail;
        else if (cyc == cur_e + 1)
          m_fault = (m_fault & ~{4{clr_s}}) | cur_fail;
        else if (clr_s)
          m_fault = '0;
        chk("count_valid", 128'(count_valid), 128'(exp_cv));
        chk("ch_count", 128'(ch_count), 128'(m_cnt));
        chk("ch_in_range", 128'(ch_in_range), 128'(m_inr));
        chk("ch_fault", 128'(ch_fault), 128'(m_fault));
        chk("count_valid_w4", 128'(count_valid4), 128'(exp_cv));
        chk("ch_count_w4", 128'(ch_count4), 128'(m_cnt4));
      end
    end
  end

  initial begin
    int n0, e0;
    pl_reset_n = 1'b0;
    enable = 1'b0;
    fault_clr = 1'b0;
    ch_tog = '0;
    ch_min = '0;
    ch_max = '0;
    min4 = '0;
    max4 = 16'hFFFF;
`ifdef CLK_FMEAS_MON_IRQ_EN
    irq_mask = 4'hF;
`endif
    repeat (3) @(negedge pl_clk0);
    chk("rst_count_valid", 128'(count_valid), 128'(0));
    chk("rst_ch_count", 128'(ch_count), 128'(0));
    chk("rst_in_range", 128'(ch_in_range), 128'(0));
    chk("rst_fault", 128'(ch_fault), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    pl_reset_n = 1'b1;
    mon_on = 1;
    tog_on = 1;
    repeat (10) @(negedge pl_clk0);

    // Three back-to-back windows; ch1 dead for two, then recovers.
    ch_min[0 +: 24] = 24'd45;
    ch_max[0 +: 24] = 24'd55;
    ch_min[24 +: 24] = 24'd1;
    ch_max[24 +: 24] = 24'd1000;
    ch_min[48 +: 24] = 24'($urandom_range(35, 20));
    ch_max[48 +: 24] = ch_min[48 +: 24] + 24'($urandom_range(10, 0));
    ch_min[72 +: 24] = 24'd0;
    ch_max[72 +: 24] = 24'($urandom_range(30, 15));
    ch1_hold = 1;
    n0 = cyc;
    enable = 1'b1;
    e0 = n0 + G + 3;
    for (int k = 0; k < 3; k++) exp_e.push_back(e0 + k * (G + 2));
    wait_to(e0);
    chk("ch0_count", 128'(ch_count[0 +: 24]), 128'(50));
    chk("ch0_in_range", 128'(ch_in_range[0]), 128'(1));
    wait_to(e0 + G + 2);
    ch1_hold = 0;
    wait_to(e0 + 2 * (G + 2) - 1);
    enable = 1'b0;
    wait_to(e0 + 2 * (G + 2) + 2);
    chk("ch1_recovered", 128'(ch_in_range[1]), 128'(1));
    chk("fault1_sticky", 128'(ch_fault[1]), 128'(1));
    chk("ch0_no_fault", 128'(ch_fault[0]), 128'(0));

    // Plain clear with no latch pending.
    fault_clr = 1'b1;
    @(negedge pl_clk0);
    fault_clr = 1'b0;
    chk("fault1_cleared", 128'(ch_fault[1]), 128'(0));

    // Clear coincides with a failing result: the set must win.
    repeat (4) @(negedge pl_clk0);
    ch1_hold = 1;
    repeat (10) @(negedge pl_clk0);
    n0 = cyc;
    enable = 1'b1;
    exp_e.push_back(n0 + G + 3);
    wait_to(n0 + G + 2);
    enable = 1'b0;
    wait_to(n0 + G + 3);
    fault_clr = 1'b1;
    @(negedge pl_clk0);
    fault_clr = 1'b0;
    chk("clr_vs_set", 128'(ch_fault[1]), 128'(1));

    // Abort at gate cycle 40, then a clean re-run.
    repeat (5) @(negedge pl_clk0);
    n0 = cyc;
    enable = 1'b1;
    wait_to(n0 + 42);
    chk("busy_gate", 128'(busy), 128'(1));
    enable = 1'b0;
    @(negedge pl_clk0);
    chk("abort_busy", 128'(busy), 128'(0));
    repeat (20) @(negedge pl_clk0);
    n0 = cyc;
    enable = 1'b1;
    exp_e.push_back(n0 + G + 3);
    wait_to(n0 + G + 2);
    enable = 1'b0;
    wait_to(n0 + G + 6);

    // Asynchronous reset mid-gate.
    n0 = cyc;
    enable = 1'b1;
    wait_to(n0 + 50);
    chk("busy_pre_rst", 128'(busy), 128'(1));
    pl_reset_n = 1'b0;
    enable = 1'b0;
    exp_e.delete();
    #1;
    chk("arst_count_valid", 128'(count_valid), 128'(0));
    chk("arst_ch_count", 128'(ch_count), 128'(0));
    chk("arst_in_range", 128'(ch_in_range), 128'(0));
    chk("arst_fault", 128'(ch_fault), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_ch_count_w4", 128'(ch_count4), 128'(0));
    repeat (3) @(negedge pl_clk0);
    pl_reset_n = 1'b1;
    repeat (10) @(negedge pl_clk0);

    // Restart with an impossible ch2 floor.
    ch_min[48 +: 24] = 24'd1000;
    n0 = cyc;
    enable = 1'b1;
    exp_e.push_back(n0 + G + 3);
    wait_to(n0 + G + 2);
    enable = 1'b0;
    wait_to(n0 + G + 6);
    chk("fault2_set", 128'(ch_fault[2]), 128'(1));
`ifdef CLK_FMEAS_MON_IRQ_EN
    irq_mask = 4'hF;
    repeat (2) @(negedge pl_clk0);
    chk("irq_masked", 128'(irq), 128'(0));
    irq_mask = 4'hB;
    @(negedge pl_clk0);
    chk("irq_unmasked", 128'(irq), 128'(1));
`endif
    repeat (5) @(negedge pl_clk0);
    if (sb.size() != 0 || exp_e.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL pending_results: %0d left", sb.size() + exp_e.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
